// File: rtl/status_reg_stack.sv
// Processor-style status flag register with a LIFO flag-save stack and a
// registered condition-code evaluator.
module status_reg_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word_out,
    input  logic             cout,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             sub,
    input  logic             update,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_sticky,
    input  logic [3:0]       cond_sel,
    output logic             V,
    output logic             Z,
    output logic             S,
    output logic             C,
    output logic             sticky_v,
    output logic             cond_true,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic             ovf_err,
    output logic             unf_err
);

    logic       b_eff;
    logic       v_next;
    logic       z_next;
    logic       s_next;
    logic       c_next;
    logic [3:0] flags;
    logic [3:0] top_entry;
    logic       do_push;
    logic       do_pop;
    logic       load_new;
    logic       push_err;
    logic       pop_err;
    logic       cond_eval;
    logic [3:0] stack_mem [DEPTH];

    assign b_eff  = b_msb ^ sub;
    assign v_next = (a_msb == b_eff) & (word_out[WIDTH-1] != a_msb);
    assign z_next = (word_out == '0);
    assign s_next = word_out[WIDTH-1];
    assign c_next = cout;

    assign flags = {V, Z, S, C};
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    assign do_push  = push & ~pop & ~full;
    assign do_pop   = pop & ~push & ~empty;
    assign push_err = push & ~pop & full;
    assign pop_err  = pop & ~push & empty;
    // A simultaneous push+pop cancels out, so the update still goes through.
    assign load_new = update & (~pop | push);

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && level == LW'(i)) begin
                stack_mem[i] <= flags;
            end
        end
    end

    always_comb begin
        top_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level == LW'(i + 1)) begin
                top_entry = stack_mem[i];
            end
        end
    end

    always_comb begin
        cond_eval = 1'b0;
        case (cond_sel)
            4'd0:  cond_eval = 1'b1;
            4'd1:  cond_eval = Z;
            4'd2:  cond_eval = ~Z;
            4'd3:  cond_eval = C;
            4'd4:  cond_eval = ~C;
            4'd5:  cond_eval = S;
            4'd6:  cond_eval = ~S;
            4'd7:  cond_eval = V;
            4'd8:  cond_eval = ~V;
            4'd9:  cond_eval = (S == V);
            4'd10: cond_eval = (S != V);
            4'd11: cond_eval = ~Z & (S == V);
            4'd12: cond_eval = Z | (S != V);
            4'd13: cond_eval = C & ~Z;
            4'd14: cond_eval = ~C | Z;
            default: cond_eval = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {V, Z, S, C} <= 4'b0000;
            sticky_v     <= 1'b0;
            cond_true    <= 1'b0;
            level        <= '0;
            ovf_err      <= 1'b0;
            unf_err      <= 1'b0;
        end else begin
            if (do_pop) begin
                {V, Z, S, C} <= top_entry;
            end else if (load_new) begin
                {V, Z, S, C} <= {v_next, z_next, s_next, c_next};
            end

            if (do_push) begin
                level <= level + LW'(1);
            end else if (do_pop) begin
                level <= level - LW'(1);
            end

            if (clr_sticky) begin
                sticky_v <= load_new & v_next;
            end else if (load_new & v_next) begin
                sticky_v <= 1'b1;
            end

            // Error set takes priority over a same-cycle clear.
            ovf_err   <= push_err | (ovf_err & ~clr_sticky);
            unf_err   <= pop_err | (unf_err & ~clr_sticky);
            cond_true <= cond_eval;
        end
    end

endmodule

// File: tb/tb_status_reg_stack.sv
// Scoreboard bench for status_reg_stack: directed vectors push expectations,
// a monitor compares after every rising edge.
module tb_status_reg_stack;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(DEPTH + 1);

    localparam int M_FLG = 1;
    localparam int M_STK = 2;
    localparam int M_CND = 4;
    localparam int M_LVL = 8;
    localparam int M_ERR = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] word_out = '0;
    logic             cout = 1'b0;
    logic             a_msb = 1'b0;
    logic             b_msb = 1'b0;
    logic             sub = 1'b0;
    logic             update = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clr_sticky = 1'b0;
    logic [3:0]       cond_sel = 4'd0;
    logic             V, Z, S, C;
    logic             sticky_v, cond_true, full, empty, ovf_err, unf_err;
    logic [LW-1:0]    level;

    typedef struct {
        int         id;
        int         mask;
        logic [3:0] f;
        logic       stk;
        logic       cnd;
        int         lvl;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   vec_id = 0;

    status_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .word_out(word_out), .cout(cout),
        .a_msb(a_msb), .b_msb(b_msb), .sub(sub), .update(update),
        .push(push), .pop(pop), .clr_sticky(clr_sticky), .cond_sel(cond_sel),
        .V(V), .Z(Z), .S(S), .C(C), .sticky_v(sticky_v), .cond_true(cond_true),
        .full(full), .empty(empty), .level(level),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clear_inputs();
        word_out = '0; cout = 0; a_msb = 0; b_msb = 0; sub = 0;
        update = 0; push = 0; pop = 0; clr_sticky = 0; cond_sel = 4'd0;
    endtask

    task automatic set_alu(input logic [3:0] wo, input logic co, input logic am,
                           input logic bm, input logic sb);
        word_out = wo; cout = co; a_msb = am; b_msb = bm; sub = sb; update = 1;
    endtask

    task automatic tick(input int mask, input logic [3:0] f, input logic stk,
                        input logic cnd, input int lvl, input logic ovf, input logic unf);
        exp_t e;
        e.id = vec_id; e.mask = mask; e.f = f; e.stk = stk; e.cnd = cnd;
        e.lvl = lvl; e.ovf = ovf; e.unf = unf;
        vec_id++;
        sb_q.push_back(e);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".flags"}, {4'b0, V, Z, S, C}, 8'h0);
        check({tag, ".sticky"}, {7'b0, sticky_v}, 8'h0);
        check({tag, ".cond"}, {7'b0, cond_true}, 8'h0);
        check({tag, ".level"}, 8'(level), 8'h0);
        check({tag, ".empty"}, {7'b0, empty}, 8'h1);
        check({tag, ".full"}, {7'b0, full}, 8'h0);
        check({tag, ".errs"}, {6'b0, ovf_err, unf_err}, 8'h0);
    endtask

    // Monitor: one expectation per driven cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if ((e.mask & M_FLG) != 0)
                    check($sformatf("v%0d.flags", e.id), {4'b0, V, Z, S, C}, {4'b0, e.f});
                if ((e.mask & M_STK) != 0)
                    check($sformatf("v%0d.sticky_v", e.id), {7'b0, sticky_v}, {7'b0, e.stk});
                if ((e.mask & M_CND) != 0)
                    check($sformatf("v%0d.cond_true", e.id), {7'b0, cond_true}, {7'b0, e.cnd});
                if ((e.mask & M_LVL) != 0) begin
                    check($sformatf("v%0d.level", e.id), 8'(level), 8'(e.lvl));
                    check($sformatf("v%0d.full", e.id), {7'b0, full}, {7'b0, e.lvl == DEPTH});
                    check($sformatf("v%0d.empty", e.id), {7'b0, empty}, {7'b0, e.lvl == 0});
                end
                if ((e.mask & M_ERR) != 0)
                    check($sformatf("v%0d.errs", e.id), {6'b0, ovf_err, unf_err}, {6'b0, e.ovf, e.unf});
            end
        end
    end

    initial begin
        #100000;
        n_chk++;
        $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3;
        check_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // zero result with carry
        set_alu(4'b0000, 1, 0, 0, 0);
        tick(M_FLG | M_STK | M_CND, 4'b0101, 0, 1, 0, 0, 0);
        cond_sel = 4'd1;
        tick(M_FLG | M_CND, 4'b0101, 0, 1, 0, 0, 0);
        // add overflow, sticky behaviour
        set_alu(4'b1000, 0, 0, 0, 0); cond_sel = 4'd1;
        tick(M_FLG | M_STK | M_CND, 4'b1010, 1, 1, 0, 0, 0);
        set_alu(4'b0011, 0, 0, 0, 0); cond_sel = 4'd7;
        tick(M_FLG | M_STK | M_CND, 4'b0000, 1, 1, 0, 0, 0);
        clr_sticky = 1; cond_sel = 4'd7;
        tick(M_FLG | M_STK | M_CND, 4'b0000, 0, 0, 0, 0, 0);
        // subtract overflow vs. add with same operands
        set_alu(4'b0111, 1, 1, 0, 1);
        tick(M_FLG | M_STK, 4'b1001, 1, 0, 0, 0, 0);
        set_alu(4'b0111, 1, 1, 0, 0); clr_sticky = 1;
        tick(M_FLG | M_STK, 4'b0001, 0, 0, 0, 0, 0);
        set_alu(4'b0111, 1, 1, 0, 1); clr_sticky = 1;
        tick(M_FLG | M_STK, 4'b1001, 1, 0, 0, 0, 0);
        clr_sticky = 1;
        tick(M_FLG | M_STK, 4'b1001, 0, 0, 0, 0, 0);
        // condition codes with S=1, V=0, Z=0, C=0
        set_alu(4'b1100, 0, 1, 1, 0);
        tick(M_FLG, 4'b0010, 0, 0, 0, 0, 0);
        cond_sel = 4'd10; tick(M_CND, 4'b0, 0, 1, 0, 0, 0);
        cond_sel = 4'd9;  tick(M_CND, 4'b0, 0, 0, 0, 0, 0);
        cond_sel = 4'd15; tick(M_CND, 4'b0, 0, 0, 0, 0, 0);
        cond_sel = 4'd12; tick(M_CND, 4'b0, 0, 1, 0, 0, 0);
        cond_sel = 4'd14; tick(M_CND, 4'b0, 0, 1, 0, 0, 0);
        cond_sel = 4'd11; tick(M_CND, 4'b0, 0, 0, 0, 0, 0);
        cond_sel = 4'd6;  tick(M_CND, 4'b0, 0, 0, 0, 0, 0);
        cond_sel = 4'd2;  tick(M_CND | M_FLG, 4'b0010, 0, 1, 0, 0, 0);
        // fill the stack; each push saves the pre-update flags
        push = 1; set_alu(4'b0000, 0, 0, 0, 0);
        tick(M_FLG | M_LVL | M_ERR, 4'b0100, 0, 0, 1, 0, 0);
        push = 1; set_alu(4'b0000, 1, 0, 0, 0);
        tick(M_FLG | M_LVL, 4'b0101, 0, 0, 2, 0, 0);
        push = 1; set_alu(4'b1000, 1, 0, 0, 0);
        tick(M_FLG | M_LVL | M_STK, 4'b1011, 1, 0, 3, 0, 0);
        push = 1; set_alu(4'b0001, 1, 0, 0, 0);
        tick(M_FLG | M_LVL | M_ERR, 4'b0001, 0, 0, 4, 0, 0);
        push = 1;
        tick(M_FLG | M_LVL | M_ERR, 4'b0001, 0, 0, 4, 1, 0);
        // drain in LIFO order; pop overrides a concurrent update
        pop = 1; set_alu(4'b0000, 0, 0, 0, 0);
        tick(M_FLG | M_LVL | M_ERR, 4'b1011, 0, 0, 3, 1, 0);
        pop = 1; tick(M_FLG | M_LVL, 4'b0101, 0, 0, 2, 0, 0);
        pop = 1; tick(M_FLG | M_LVL, 4'b0100, 0, 0, 1, 0, 0);
        pop = 1; tick(M_FLG | M_LVL, 4'b0010, 0, 0, 0, 0, 0);
        pop = 1; set_alu(4'b0001, 1, 0, 0, 0);
        tick(M_FLG | M_LVL | M_ERR, 4'b0010, 0, 0, 0, 1, 1);
        // clear errors, push+pop no-op with update, set-beats-clear
        clr_sticky = 1;
        tick(M_ERR | M_STK, 4'b0, 0, 0, 0, 0, 0);
        push = 1; pop = 1; set_alu(4'b0000, 1, 0, 0, 0);
        tick(M_FLG | M_LVL | M_ERR, 4'b0101, 0, 0, 0, 0, 0);
        pop = 1; clr_sticky = 1;
        tick(M_ERR | M_LVL, 4'b0, 0, 0, 0, 0, 1);
        clr_sticky = 1;
        tick(M_ERR, 4'b0, 0, 0, 0, 0, 0);
        // asynchronous reset mid-operation
        push = 1; tick(M_LVL | M_CND, 4'b0, 0, 1, 1, 0, 0);
        push = 1; tick(M_LVL | M_CND, 4'b0, 0, 1, 2, 0, 0);
        #2;
        push = 1;
        rst_n = 0;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        push = 0;
        rst_n = 1;
        tick(M_FLG | M_LVL | M_ERR | M_CND, 4'b0000, 0, 1, 0, 0, 0);
        push = 1;
        tick(M_LVL, 4'b0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/status_reg_stack.md
STATUS_REG_STACK -- requirements
Module: status_reg_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 4: datapath word width, minimum 2.
REQ-002 SHALL have parameter DEPTH, default 4: flag-save stack entries, minimum 1.
REQ-003 SHALL have input clk, 1 bit: sole clock; all state updates on the rising edge.
REQ-004 SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input word_out, WIDTH bits: ALU result word.
REQ-006 SHALL have input cout, 1 bit: ALU carry-out.
REQ-007 SHALL have inputs a_msb and b_msb, 1 bit each: operand sign bits as presented to the ALU.
REQ-008 SHALL have input sub, 1 bit: 1 = subtract (B inverted), 0 = add.
REQ-009 SHALL have input update, 1 bit: load new flags this cycle.
REQ-010 SHALL have inputs push and pop, 1 bit each: save flags to the stack / restore flags from the stack.
REQ-011 SHALL have input clr_sticky, 1 bit: clear sticky_v, ovf_err and unf_err.
REQ-012 SHALL have input cond_sel, 4 bits: condition-code select.
REQ-013 SHALL have outputs V, Z, S and C, 1 bit each: registered overflow, zero, sign and carry flags.
REQ-014 SHALL have output sticky_v, 1 bit: accumulated overflow.
REQ-015 SHALL have output cond_true, 1 bit: registered result of the condition evaluation.
REQ-016 SHALL have outputs full and empty, 1 bit each, and output level, clog2(DEPTH+1) bits: stack occupancy.
REQ-017 SHALL have outputs ovf_err and unf_err, 1 bit each: sticky flags for push-when-full and pop-when-empty.

Function
REQ-018 SHALL compute next-flag values combinationally: b_eff = b_msb ^ sub; Vn = (a_msb == b_eff) & (word_out[WIDTH-1] != a_msb); Zn = (word_out == 0); Sn = word_out[WIDTH-1]; Cn = cout.
REQ-019 SHALL, when update=1 and pop=0, load {V,Z,S,C} <= {Vn,Zn,Sn,Cn} at the edge, visible one cycle after the inputs are sampled; otherwise V, Z, S and C SHALL hold their values.
REQ-020 SHALL set sticky_v at the edge when update=1, pop=0 and Vn=1; clr_sticky=1 SHALL clear it; when clr_sticky=1 and update=1 occur together, sticky_v SHALL take Vn.
REQ-021 SHALL implement the stack as a LIFO of DEPTH 4-bit entries {V,Z,S,C}; level counts valid entries 0..DEPTH; empty = (level==0); full = (level==DEPTH).
REQ-022 SHALL, on push=1, pop=0 and not full, write the current registered flags (pre-update) to the top entry and increment level; a concurrent update SHALL still load the new flags.
REQ-023 SHALL, on pop=1, push=0 and not empty, load {V,Z,S,C} from the top entry and decrement level; pop SHALL override update in the same cycle, and sticky_v SHALL be unchanged.
REQ-024 SHALL ignore push when full and set ovf_err; SHALL ignore pop when empty (flags and level unchanged) and set unf_err.
REQ-025 SHALL treat push=1 with pop=1 as a no-op on both the stack and the flags, with no error set; update in that cycle SHALL still apply.
REQ-026 SHALL clear ovf_err and unf_err with clr_sticky; when a set condition and clr_sticky occur in the same cycle, set SHALL win.
REQ-027 SHALL register cond_true every cycle from the current registered flags, giving one-cycle latency: 0 1; 1 Z; 2 !Z; 3 C; 4 !C; 5 S; 6 !S; 7 V; 8 !V; 9 S==V; 10 S!=V; 11 !Z&(S==V); 12 Z|(S!=V); 13 C&!Z; 14 !C|Z; 15 0.

Reset
REQ-028 SHALL, while rst_n=0, drive V=Z=S=C=0, sticky_v=0, cond_true=0, level=0, empty=1, full=0 and ovf_err=unf_err=0, independent of clk; stack contents are don't-care.
REQ-029 SHALL, on assertion of rst_n mid-operation, abandon any push or pop in flight, and SHALL accept the first operation on the first rising edge after deassertion.

Verification
REQ-030 SHALL be verified with WIDTH=4: update, word_out=0000, cout=1, a_msb=b_msb=0, sub=0 -> next cycle Z=1, C=1, S=0, V=0.
REQ-031 SHALL be verified with: update, a_msb=0, b_msb=0, sub=0, word_out=1000 -> V=1, S=1, sticky_v=1; then update with Vn=0 -> V=0, sticky_v still 1; then clr_sticky -> sticky_v=0.
REQ-032 SHALL be verified with: subtract, a_msb=1, b_msb=0, sub=1, word_out=0111 -> V=1; the same stimulus with sub=0 -> V=0.
REQ-033 SHALL be verified with DEPTH=4: four pushes with distinct flags -> full=1, level=4; a fifth push -> ovf_err=1, level=4; four pops restore the flags in LIFO order; a fifth pop -> unf_err=1, flags unchanged.
REQ-034 SHALL be verified with: flags S=1, V=0, cond_sel=10 -> cond_true=1 one cycle later; cond_sel=9 -> cond_true=0; cond_sel=15 -> 0.
REQ-035 SHALL be verified with: rst_n pulsed low between edges after two pushes -> all outputs reach reset values immediately, and level=0 after release.
